// File: rtl/ui_pkg.sv
// -----------------------------------------------------------------------------
// ui_pkg
// Shared definitions for the board UI input path (switch/key debouncing).
//   - db_state_t and the four debounce FSM state codes
//   - clog2_min1(): counter width helper that never returns zero
// -----------------------------------------------------------------------------
package ui_pkg;

    typedef logic [1:0] db_state_t;

    localparam db_state_t IDLE   = 2'b00;  // settled low
    localparam db_state_t DELAY0 = 2'b01;  // low, input high, timing the press
    localparam db_state_t ONE    = 2'b10;  // settled high
    localparam db_state_t DELAY1 = 2'b11;  // high, input low, timing the release

    // Number of bits needed to hold 0..value-1, and at least 1, so that a
    // count range of 1 or 2 still gives a legal vector width.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : ui_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounce channel: 2-flop synchroniser, four-state debounce FSM with an
// exact DB_CYCLES stability time, and an optional hold/auto-repeat counter.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sw         in   raw asynchronous switch input, active high
//   db_level   out  debounced level (registered)
//   rise_tick  out  1-cycle pulse on an accepted press (registered)
//   fall_tick  out  1-cycle pulse on an accepted release (registered)
//   rep_tick   out  1-cycle auto-repeat pulse while held (registered, or 0)
// -----------------------------------------------------------------------------
module debounce_ch
    import ui_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick,
    output logic rep_tick
);

    localparam int TW = clog2_min1(DB_CYCLES);
    localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Input synchroniser: sync_q[0] may go metastable, sync_q[1] is clean.
    // -------------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       sw_s;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sw};
        end
    end

    assign sw_s = sync_q[1];

    // -------------------------------------------------------------------------
    // Debounce FSM: state register
    // -------------------------------------------------------------------------
    db_state_t      state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (sw_s) begin
                    timer_d = '0;
                    state_d = DELAY0;
                end
            end
            DELAY0: begin
                if (!sw_s) begin
                    state_d = IDLE;
                end else if (timer_q == DB_LAST) begin
                    state_d = ONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ONE: begin
                if (!sw_s) begin
                    timer_d = '0;
                    state_d = DELAY1;
                end
            end
            DELAY1: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (timer_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: output logic
    // Outputs are decoded from the transition being taken and registered, so
    // db_level and the ticks change on the same edge as the state itself.
    // -------------------------------------------------------------------------
    logic level_d, rise_d, fall_d;

    always_comb begin
        level_d = (state_d == ONE) || (state_d == DELAY1);
        rise_d  = (state_q == DELAY0) && (state_d == ONE);
        fall_d  = (state_q == DELAY1) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level  <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            db_level  <= level_d;
            rise_tick <= rise_d;
            fall_tick <= fall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Hold / auto-repeat
    // The counter only advances on edges where the FSM is in ONE and stays
    // there; it freezes across a DELAY1 excursion that bounces back to ONE.
    // phase_q = 0 : waiting HOLD_CYCLES for the first repeat
    // phase_q = 1 : waiting REPEAT_CYCLES between subsequent repeats
    // -------------------------------------------------------------------------
    if (REPEAT_EN) begin : g_hold
        localparam int HW = clog2_min1((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                     : REPEAT_CYCLES);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
        localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

        logic [HW-1:0] hold_q;
        logic          phase_q;
        logic          rep_q;
        logic          staying_one;
        logic          hold_hit;

        always_comb begin
            staying_one = (state_q == ONE) && sw_s;
            hold_hit    = staying_one && (hold_q == (phase_q ? REP_LAST : HOLD_LAST));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q  <= '0;
                phase_q <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= hold_hit;
                if (rise_d || (state_d == IDLE)) begin
                    hold_q  <= '0;
                    phase_q <= 1'b0;
                end else if (staying_one) begin
                    if (hold_hit) begin
                        hold_q  <= '0;
                        phase_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
            end
        end

        assign rep_tick = rep_q;
    end else begin : g_no_hold
        assign rep_tick = 1'b0;
    end

endmodule : debounce_ch

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// N_CH independent switch/key debouncers for the board UI path.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sw         in   [N_CH] raw asynchronous switch inputs, active high
//   db_level   out  [N_CH] debounced level per channel
//   rise_tick  out  [N_CH] 1-cycle pulse on accepted press
//   fall_tick  out  [N_CH] 1-cycle pulse on accepted release
//   rep_tick   out  [N_CH] 1-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick,
    output logic [N_CH-1:0] rep_tick
);

    // Parameter legality: stop elaboration on values the channel logic
    // cannot represent.
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("debounce_multi: N_CH must be in 1..16");
    end
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("debounce_multi: DB_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("debounce_multi: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("debounce_multi: REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .sw        (sw[i]),
            .db_level  (db_level[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .rep_tick  (rep_tick[i])
        );
    end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Self-checking bench for debounce_multi (N_CH=4, DB=4, HOLD=6, REPEAT=3).
// The reference model describes each channel by how many consecutive sampled
// edges the synchronised input has disagreed with the debounced level (a
// change is accepted on the DB+1-th disagreeing edge) and by how many edges
// the key has been held settled high since the press.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int N_CH = 4;
    localparam int DB   = 4;
    localparam int HOLD = 6;
    localparam int REP  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] db_level, rise_tick, fall_tick, rep_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH          (N_CH),
        .DB_CYCLES     (DB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .REPEAT_EN     (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .rep_tick  (rep_tick)
    );

    // ---------------------------------------------------------------- model
    bit [N_CH-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_rep;
    int            run  [N_CH];
    int            held [N_CH];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_rise = '0; m_fall = '0; m_rep = '0;
        for (int c = 0; c < N_CH; c++) begin
            run[c]  = 0;
            held[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit [N_CH-1:0] seen;
        bit            settled_high;
        seen = m_s2;          // value the debouncer acts on at this edge
        m_s2 = m_s1;
        m_s1 = sw;
        m_rise = '0; m_fall = '0; m_rep = '0;
        for (int c = 0; c < N_CH; c++) begin
            settled_high = m_level[c] && (run[c] == 0);
            if (seen[c] != m_level[c]) run[c]++;
            else                       run[c] = 0;
            if (run[c] == DB + 1) begin
                m_level[c] = ~m_level[c];
                run[c]     = 0;
                held[c]    = 0;
                if (m_level[c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
            end else if (settled_high && seen[c]) begin
                held[c]++;
                if (held[c] == HOLD || (held[c] > HOLD && (held[c] - HOLD) % REP == 0))
                    m_rep[c] = 1'b1;
            end
        end
    endtask

    // ---------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model, then compare all outputs 1 ns later.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_edge();
            #1;
            check("db_level",  32'(db_level),  32'(m_level));
            check("rise_tick", 32'(rise_tick), 32'(m_rise));
            check("fall_tick", 32'(fall_tick), 32'(m_fall));
            check("rep_tick",  32'(rep_tick),  32'(m_rep));
        end
    endtask

    // Steps until rise_tick[ch] is seen; lat = edges taken, -1 if the bound expires.
    task automatic wait_rise(input int ch, input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            step(1);
            if (rise_tick[ch]) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int lat, reps, first_rep, falls, late_reps, remain [N_CH];
        logic [N_CH-1:0] seen_vec;

        // Reset then idle
        rst_n = 1'b0;
        sw    = '0;
        model_reset();
        step(3);
        rst_n = 1'b1;
        step(3);

        // Clean press on ch0: the edge sampling sw high is edge 1, rise after edge 7
        sw[0] = 1'b1;
        wait_rise(0, 20, lat);
        check("press_latency", 32'(lat), 32'd7);
        check("press_others_quiet", 32'(rise_tick[3:1]), 32'd0);
        step(1);
        check("rise_one_cycle", 32'(rise_tick[0]), 32'd0);
        sw[0] = 1'b0;
        step(12);

        // Bounce rejection on ch1, press side then release side
        sw[1] = 1'b1; step(3);
        sw[1] = 1'b0; step(10);
        check("bounce_press_level", 32'(db_level[1]), 32'd0);
        sw[1] = 1'b1; step(10);
        sw[1] = 1'b0; step(3);
        sw[1] = 1'b1; step(10);
        check("bounce_release_level", 32'(db_level[1]), 32'd1);
        sw[1] = 1'b0; step(12);

        // Hold / auto-repeat on ch2
        sw[2] = 1'b1;
        wait_rise(2, 20, lat);
        check("hold_press_seen", 32'(lat), 32'd7);
        reps = 0; first_rep = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (rep_tick[2]) begin
                reps++;
                if (first_rep < 0) first_rep = k;
            end
        end
        check("first_rep_offset", 32'(first_rep), 32'd6);
        check("rep_count_20", 32'(reps), 32'd5);
        sw[2] = 1'b0;
        falls = 0; late_reps = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (falls > 0 && rep_tick[2]) late_reps++;
            if (fall_tick[2]) falls++;
        end
        check("hold_fall_once", 32'(falls), 32'd1);
        check("no_rep_after_fall", 32'(late_reps), 32'd0);

        // Simultaneous press and release on all channels
        sw = '1;
        seen_vec = '0;
        for (int k = 0; k < 20 && seen_vec == '0; k++) begin
            step(1);
            seen_vec = rise_tick;
        end
        check("simul_rise", 32'(seen_vec), 32'hF);
        sw = '0;
        seen_vec = '0;
        for (int k = 0; k < 20 && seen_vec == '0; k++) begin
            step(1);
            seen_vec = fall_tick;
        end
        check("simul_fall", 32'(seen_vec), 32'hF);
        step(3);

        // Async reset mid-hold (ch2) and mid-DELAY0 (ch0)
        sw[2] = 1'b1;
        wait_rise(2, 20, lat);
        step(8);
        sw[0] = 1'b1;
        step(3);
        check("pre_reset_level", 32'(db_level), 32'h4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_level", 32'(db_level), 32'h0);
        check("async_rst_ticks", 32'({rise_tick, fall_tick, rep_tick}), 32'h0);
        #2;
        rst_n = 1'b1;
        wait_rise(0, 20, lat);
        check("post_reset_latency", 32'(lat), 32'd7);
        check("post_reset_ch2_rise", 32'(rise_tick[2]), 32'd1);
        sw = '0;
        step(12);

        // Randomised per-channel activity: short bounces and long holds
        for (int c = 0; c < N_CH; c++) remain[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (remain[c] == 0) begin
                    sw[c]     = ~sw[c];
                    remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                                            : $urandom_range(1, 8);
                end else begin
                    remain[c]--;
                end
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_debounce_multi
